// File: rtl/trig_pll_lock_ctrl.sv
// Reset/lock sequencer for the trigger PLL: holds the PLL in reset, qualifies the
// synchronized locked flag, retries a bounded number of times and publishes o_ready.
module trig_pll_lock_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_pll_locked,
    input  logic             i_relock,
    input  logic             i_clr_cnt,
    output logic             o_pll_rst,
    output logic             o_ready,
    output logic             o_error,
    output logic [2:0]       o_state,
    output logic [3:0]       o_retry_cnt,
    output logic [CNT_W-1:0] o_loss_cnt
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_READY  = 3'd3,
        S_FAIL   = 3'd4
    } state_t;

    localparam int T_MAX = (RST_CYCLES > LOCK_TIMEOUT) ?
                           ((RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES) :
                           ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
    localparam int TMR_W = $clog2(T_MAX + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             w_lock_s;
    state_t           r_state;
    state_t           w_nxt;
    logic [TMR_W-1:0] r_timer;
    logic             w_tmr_clr;
    logic             w_tmr_run;
    logic [3:0]       r_retry;
    logic [3:0]       w_retry_inc;
    logic             w_fail_att;
    logic             w_loss;
    logic             w_ready_entry;
    logic [CNT_W-1:0] r_loss;
    logic             r_pll_rst;
    logic             r_ready;
    logic             r_error;

    // i_pll_locked is asynchronous to i_clk; two-flop synchronizer
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pll_locked;
            r_sync2 <= r_sync1;
        end
    end

    assign w_lock_s = r_sync2;

    always_comb begin
        w_nxt       = r_state;
        w_fail_att  = 1'b0;
        w_loss      = 1'b0;
        w_retry_inc = r_retry + 4'd1;
        if (i_relock) begin
            w_nxt = S_RESET;
        end else begin
            case (r_state)
                S_RESET: begin
                    if (r_timer == TMR_W'(RST_CYCLES - 1)) w_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (w_lock_s) w_nxt = S_STABLE;
                    else if (r_timer == TMR_W'(LOCK_TIMEOUT - 1)) w_fail_att = 1'b1;
                end
                S_STABLE: begin
                    if (!w_lock_s) w_fail_att = 1'b1;
                    else if (r_timer == TMR_W'(STABLE_CYCLES - 1)) w_nxt = S_READY;
                end
                S_READY: begin
                    if (!w_lock_s) begin
                        w_loss = 1'b1;
                        w_nxt  = S_RESET;
                    end
                end
                S_FAIL:  w_nxt = S_FAIL;
                default: w_nxt = S_RESET;
            endcase
            if (w_fail_att) w_nxt = (w_retry_inc == 4'(MAX_RETRIES)) ? S_FAIL : S_RESET;
        end
    end

    // A relock restarts the timer even when it arrives while already in RESET
    assign w_tmr_clr     = i_relock || (w_nxt != r_state);
    assign w_tmr_run     = (r_state == S_RESET) || (r_state == S_WAIT) || (r_state == S_STABLE);
    assign w_ready_entry = (w_nxt == S_READY) && (r_state != S_READY);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_RESET;
            r_timer <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_tmr_clr)      r_timer <= '0;
            else if (w_tmr_run) r_timer <= r_timer + TMR_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_retry <= '0;
        end else if (i_relock || w_ready_entry) begin
            r_retry <= '0;
        end else if (w_fail_att) begin
            r_retry <= w_retry_inc;
        end
    end

    // Clear has priority over a coincident loss event
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_loss <= '0;
        end else if (i_clr_cnt) begin
            r_loss <= '0;
        end else if (w_loss && !(&r_loss)) begin
            r_loss <= r_loss + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pll_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_pll_rst <= (w_nxt == S_RESET) || (w_nxt == S_FAIL);
            r_ready   <= (w_nxt == S_READY);
            r_error   <= (w_nxt == S_FAIL);
        end
    end

    assign o_pll_rst   = r_pll_rst;
    assign o_ready     = r_ready;
    assign o_error     = r_error;
    assign o_state     = r_state;
    assign o_retry_cnt = r_retry;
    assign o_loss_cnt  = r_loss;

endmodule

// File: doc/trig_pll_lock_ctrl.md
Name: trig_pll_lock_ctrl

Overview:
- Reset/lock sequencer for the trigger PLL (125 MHz reference in, 500 MHz out). Runs on the free-running 125 MHz reference clock.
- Drives the PLL reset and qualifies the raw locked flag, then publishes a glitch-free ready signal to downstream trigger logic.
- Retries locking a limited number of times, then declares failure.
- Counts loss-of-lock events for slow control.

Parameters:
RST_CYCLES, 16, cycles PLL reset is held per attempt (>=1)
LOCK_TIMEOUT, 4096, max cycles waiting for synchronized lock per attempt (>=2)
STABLE_CYCLES, 256, consecutive locked cycles required before ready (>=1)
MAX_RETRIES, 4, failed attempts tolerated before FAIL (1..15)
CNT_W, 16, width of loss-of-lock counter

Ports:
i_clk  in  1  125 MHz reference clock (same net as PLL refclk)
i_reset_n  in  1  asynchronous active-low reset
i_pll_locked  in  1  raw PLL locked flag, asynchronous to i_clk
i_relock  in  1  one-cycle request: restart sequence from any state
i_clr_cnt  in  1  one-cycle request: clear o_loss_cnt
o_pll_rst  out  1  active-high reset to PLL
o_ready  out  1  PLL output usable
o_error  out  1  lock failed after MAX_RETRIES attempts
o_state  out  3  encoded state: 0 RESET, 1 WAIT_LOCK, 2 STABLE, 3 READY, 4 FAIL
o_retry_cnt  out  4  failed attempts since last success/relock
o_loss_cnt  out  CNT_W  READY->lock-loss events, saturating

Behaviour:
- Reset (i_reset_n=0, async):
  - state RESET, o_pll_rst=1, o_ready=0, o_error=0.
  - All counters 0, synchronizer cleared to 0.
- i_pll_locked passes a 2-FF synchronizer (lock_s). All decisions use lock_s, so there is 2 cycles of latency from the raw input.
- All outputs are registered. o_pll_rst=1 in RESET and FAIL, otherwise 0. o_ready=1 only in READY. o_error=1 only in FAIL.
- A single timer is cleared on every state entry.
- RESET:
  - Stays exactly RST_CYCLES cycles, then goes to WAIT_LOCK.
  - lock_s is ignored.
- WAIT_LOCK:
  - If lock_s=1, go to STABLE.
  - If timer reaches LOCK_TIMEOUT-1 with lock_s=0, it is a failed attempt.
  - If lock_s=1 on the timeout cycle, lock wins.
- STABLE:
  - If lock_s stays 1 for STABLE_CYCLES consecutive cycles, go to READY.
  - If lock_s=0 on any cycle, it is a failed attempt.
- Failed attempt:
  - o_retry_cnt increments.
  - If the new value equals MAX_RETRIES, go to FAIL; otherwise go to RESET.
- READY:
  - Entry clears o_retry_cnt.
  - If lock_s=0, o_loss_cnt increments (saturates at all-ones), o_ready drops on the next edge, and state goes to RESET.
- FAIL:
  - Terminal; PLL is held in reset.
  - Left only via i_relock or i_reset_n.
- i_relock has highest priority, in any state including RESET:
  - Next state is RESET with the timer restarted.
  - o_retry_cnt=0, o_error=0.
  - o_loss_cnt is unchanged.
  - A relock in READY does not count as a loss.
- i_clr_cnt:
  - Sets o_loss_cnt=0 next cycle.
  - If it coincides with an increment, the clear wins (result 0).
- A lock glitch shorter than 1 cycle may be missed by the synchronizer; this is accepted.
- Reset asserted mid-sequence aborts immediately to reset values.

Test Plan:
(all with RST_CYCLES=8, LOCK_TIMEOUT=100, STABLE_CYCLES=16, MAX_RETRIES=3)
1. Release reset, raw lock rises 20 cycles after reset release:
   - o_pll_rst=1 for 8 cycles, then 0.
   - o_ready rises 2 (sync) + 16 (stable) + 1 (registered) cycles after raw lock rises.
   - o_state sequence 0,1,2,3.
   - o_retry_cnt=0.
2. Lock never asserts:
   - Three attempts of 8 reset + 100 wait cycles.
   - o_retry_cnt goes 1,2,3, then o_state=4, o_error=1, o_pll_rst=1 held indefinitely.
   - Then i_relock pulse: o_error=0, o_retry_cnt=0, new 8-cycle reset.
3. In READY, drop raw lock for 3 cycles:
   - o_loss_cnt=1, o_ready=0 within 3 cycles.
   - Full resequence back to READY, o_retry_cnt=0.
4. Lock bounces during STABLE (high 10 cycles, low 1, high):
   - o_retry_cnt=1, return to RESET.
   - Then READY reached on the stable lock.
5. Preload o_loss_cnt=0xFFFF via 65535 losses (or forced):
   - The next loss keeps it at 0xFFFF.
   - i_clr_cnt on the same cycle as a loss gives 0.
6. Assert i_reset_n=0 asynchronously mid-STABLE:
   - o_pll_rst=1, o_ready=0 and all counters 0 immediately, without waiting for a clock edge.
